// File: rtl/tb_loop_sequencer.sv
// Run controller: sequences MAX_LOOP_COUNT test-body loops with heartbeat, per-loop watchdog,
// saturating error count and finished/halted/pass status for end-of-sim reporting.
module tb_loop_sequencer #(
    parameter int MAX_LOOP_COUNT   = 3,
    parameter int HEART_BEAT       = 1,
    parameter int HEARTBEAT_CYCLES = 1000,
    parameter int STOP_AT_ERROR    = 0,
    parameter int TIMEOUT_CYCLES   = 100000,
    parameter int ERR_CNT_W        = 16,
    localparam int IDX_W           = $clog2(MAX_LOOP_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 test_done,
    input  logic                 test_pass,
    input  logic                 err_in,
    output logic                 run,
    output logic [IDX_W-1:0]     loop_idx,
    output logic                 loop_done,
    output logic                 heartbeat,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 timeout,
    output logic                 finished,
    output logic                 halted,
    output logic                 pass_all
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HB_W = $clog2(HEARTBEAT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_LOOP_COUNT - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_DONE, S_HALT} state_t;

    state_t                r_state;
    logic                  r_run;
    logic [IDX_W-1:0]      r_loop_idx;
    logic                  r_loop_done;
    logic                  r_heartbeat;
    logic [ERR_CNT_W-1:0]  r_err;
    logic                  r_timeout;
    logic                  r_finished;
    logic                  r_halted;
    logic                  r_pass_all;
    logic                  r_vpass;
    logic [WD_W-1:0]       r_wd;
    logic [HB_W-1:0]       r_hb;
    logic [ERR_CNT_W-1:0]  w_err_chk;

    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                     input logic [1:0]           inc);
        logic [ERR_CNT_W:0] s;
        s = {1'b0, a} + {{(ERR_CNT_W-1){1'b0}}, inc};
        return s[ERR_CNT_W] ? '1 : s[ERR_CNT_W-1:0];
    endfunction

    // Error total as it stands once the loop verdict has been folded in
    always_comb begin
        w_err_chk = r_vpass ? r_err : sat_add(r_err, 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_loop_idx  <= '0;
            r_loop_done <= 1'b0;
            r_heartbeat <= 1'b0;
            r_err       <= '0;
            r_timeout   <= 1'b0;
            r_finished  <= 1'b0;
            r_halted    <= 1'b0;
            r_pass_all  <= 1'b0;
            r_vpass     <= 1'b0;
            r_wd        <= '0;
            r_hb        <= '0;
        end else begin
            r_loop_done <= 1'b0;
            r_heartbeat <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_wd <= r_wd + 1'b1;
                    if (r_hb == HB_LAST) begin
                        r_hb        <= '0;
                        r_heartbeat <= (HEART_BEAT != 0);
                    end else begin
                        r_hb <= r_hb + 1'b1;
                    end
                    if (err_in && (STOP_AT_ERROR != 0)) begin
                        r_err      <= sat_add(r_err, 2'd1);
                        r_state    <= S_HALT;
                        r_run      <= 1'b0;
                        r_finished <= 1'b1;
                        r_halted   <= 1'b1;
                    end else if (test_done) begin
                        r_err       <= sat_add(r_err, {1'b0, err_in});
                        r_vpass     <= test_pass;
                        r_state     <= S_CHECK;
                        r_run       <= 1'b0;
                        r_loop_done <= 1'b1;
                    end else if (r_wd == WD_LAST) begin
                        // Expiry itself counts as one error, on top of any err_in this cycle
                        r_err      <= sat_add(r_err, err_in ? 2'd2 : 2'd1);
                        r_timeout  <= 1'b1;
                        r_state    <= S_HALT;
                        r_run      <= 1'b0;
                        r_finished <= 1'b1;
                        r_halted   <= 1'b1;
                    end else begin
                        r_err <= sat_add(r_err, {1'b0, err_in});
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_chk;
                    if (!r_vpass && (STOP_AT_ERROR != 0)) begin
                        r_state    <= S_HALT;
                        r_finished <= 1'b1;
                        r_halted   <= 1'b1;
                    end else if (r_loop_idx == IDX_LAST) begin
                        r_state    <= S_DONE;
                        r_finished <= 1'b1;
                        r_pass_all <= (w_err_chk == '0);
                    end else begin
                        r_loop_idx <= r_loop_idx + 1'b1;
                        r_wd       <= '0;
                        r_hb       <= '0;
                        r_state    <= S_RUN;
                        r_run      <= 1'b1;
                    end
                end
                S_IDLE, S_DONE, S_HALT: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_run      <= 1'b1;
                        r_loop_idx <= '0;
                        r_err      <= '0;
                        r_timeout  <= 1'b0;
                        r_wd       <= '0;
                        r_hb       <= '0;
                        r_finished <= 1'b0;
                        r_halted   <= 1'b0;
                        r_pass_all <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign run       = r_run;
    assign loop_idx  = r_loop_idx;
    assign loop_done = r_loop_done;
    assign heartbeat = r_heartbeat;
    assign err_count = r_err;
    assign timeout   = r_timeout;
    assign finished  = r_finished;
    assign halted    = r_halted;
    assign pass_all  = r_pass_all;

endmodule

// File: tb/tb_tb_loop_sequencer.sv
// Randomized bench for tb_loop_sequencer: two instances (continue-on-error and stop-at-error)
// share stimulus and are compared every cycle against a loop/cycle-count reference model.
module tb_tb_loop_sequencer;

    localparam int MAXL  = 3;
    localparam int HBC   = 10;
    localparam int TO    = 50;
    localparam int EW    = 4;
    localparam int ESAT  = (1 << EW) - 1;
    localparam int P_IDLE = 0, P_RUN = 1, P_CHK = 2, P_DONE = 3, P_HALT = 4;

    logic clk = 1'b0;
    logic rst_n, start, test_done, test_pass, err_in;
    logic [1:0] run_w, ld_w, hb_w, to_w, fin_w, halt_w, pass_w;
    logic [1:0]    idx_w [2];
    logic [EW-1:0] err_w [2];

    always #5 clk = ~clk;

    tb_loop_sequencer #(.MAX_LOOP_COUNT(MAXL), .HEART_BEAT(1), .HEARTBEAT_CYCLES(HBC),
        .STOP_AT_ERROR(0), .TIMEOUT_CYCLES(TO), .ERR_CNT_W(EW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .test_pass(test_pass),
        .err_in(err_in), .run(run_w[0]), .loop_idx(idx_w[0]), .loop_done(ld_w[0]),
        .heartbeat(hb_w[0]), .err_count(err_w[0]), .timeout(to_w[0]), .finished(fin_w[0]),
        .halted(halt_w[0]), .pass_all(pass_w[0]));

    tb_loop_sequencer #(.MAX_LOOP_COUNT(MAXL), .HEART_BEAT(1), .HEARTBEAT_CYCLES(HBC),
        .STOP_AT_ERROR(1), .TIMEOUT_CYCLES(TO), .ERR_CNT_W(EW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .test_pass(test_pass),
        .err_in(err_in), .run(run_w[1]), .loop_idx(idx_w[1]), .loop_done(ld_w[1]),
        .heartbeat(hb_w[1]), .err_count(err_w[1]), .timeout(to_w[1]), .finished(fin_w[1]),
        .halted(halt_w[1]), .pass_all(pass_w[1]));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: phase of each run, cycles elapsed in the current loop, loop number, error total
    int m_ph [2], m_loop [2], m_err [2], m_cyc [2];
    bit m_to [2], m_vpass [2], m_hb [2], m_ld [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] @%0t got %0h expected %0h", tag, k, $time, obs, exp);
        end
    endtask

    task automatic model_step(input int k);
        bit stop = (k == 1);
        int add;
        m_hb[k] = 1'b0;
        m_ld[k] = 1'b0;
        if (!rst_n) begin
            m_ph[k] = P_IDLE; m_loop[k] = 0; m_err[k] = 0; m_cyc[k] = 0;
            m_to[k] = 1'b0; m_vpass[k] = 1'b0;
            return;
        end
        case (m_ph[k])
            P_RUN: begin
                m_cyc[k]++;
                m_hb[k] = (m_cyc[k] % HBC == 0);
                add = err_in ? 1 : 0;
                if (err_in && stop) m_ph[k] = P_HALT;
                else if (test_done) begin
                    m_ph[k] = P_CHK; m_vpass[k] = test_pass; m_ld[k] = 1'b1;
                end else if (m_cyc[k] == TO) begin
                    m_to[k] = 1'b1; add++; m_ph[k] = P_HALT;
                end
                m_err[k] = (m_err[k] + add > ESAT) ? ESAT : m_err[k] + add;
            end
            P_CHK: begin
                if (!m_vpass[k]) m_err[k] = (m_err[k] + 1 > ESAT) ? ESAT : m_err[k] + 1;
                if (!m_vpass[k] && stop) m_ph[k] = P_HALT;
                else if (m_loop[k] == MAXL - 1) m_ph[k] = P_DONE;
                else begin
                    m_loop[k]++; m_cyc[k] = 0; m_ph[k] = P_RUN;
                end
            end
            default: if (start) begin
                m_ph[k] = P_RUN; m_loop[k] = 0; m_err[k] = 0; m_cyc[k] = 0; m_to[k] = 1'b0;
            end
        endcase
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("run",       k, 32'(run_w[k]),  32'(m_ph[k] == P_RUN));
            chk("loop_idx",  k, 32'(idx_w[k]),  m_loop[k]);
            chk("loop_done", k, 32'(ld_w[k]),   32'(m_ld[k]));
            chk("heartbeat", k, 32'(hb_w[k]),   32'(m_hb[k]));
            chk("err_count", k, 32'(err_w[k]),  m_err[k]);
            chk("timeout",   k, 32'(to_w[k]),   32'(m_to[k]));
            chk("finished",  k, 32'(fin_w[k]),  32'(m_ph[k] == P_DONE || m_ph[k] == P_HALT));
            chk("halted",    k, 32'(halt_w[k]), 32'(m_ph[k] == P_HALT));
            chk("pass_all",  k, 32'(pass_w[k]), 32'(m_ph[k] == P_DONE && m_err[k] == 0));
        end
    endtask

    // One clock: drive at negedge with per-mille probabilities, model at posedge, check 1 time unit later
    task automatic cycle(input int p_start, input int p_done, input int p_err, input int p_pass,
                         input int p_rst);
        @(negedge clk);
        rst_n     = ($urandom_range(999) < p_rst) ? 1'b0 : 1'b1;
        start     = ($urandom_range(999) < p_start);
        test_done = ($urandom_range(999) < p_done);
        err_in    = ($urandom_range(999) < p_err);
        test_pass = ($urandom_range(999) < p_pass);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; test_done = 1'b0; test_pass = 1'b0; err_in = 1'b0;
        repeat (4) cycle(500, 500, 500, 500, 1000);
        repeat (400)  cycle(40, 100, 0,   1000, 0);
        repeat (800)  cycle(40, 50,  25,  800,  0);
        repeat (500)  cycle(80, 0,   0,   1000, 0);
        repeat (1500) cycle(40, 30,  20,  850,  4);
        repeat (1000) cycle(60, 25,  60,  700,  2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
